dmem_arbiter: RTL and testbench

Shares the single-port data memory between the processor and one secondary requester, such as the sensor/LED sampling engine. The block sits between the processor's dmem port and the dmem syncram. The processor gets fixed priority. The peripheral is granted idle slots, and an optional starvation guard stalls the processor for one cycle when the peripheral has waited too long. Read data is returned to the peripheral with a registered valid strobe.

---
 rtl/dmem_arb_pkg.sv | 17 +
 rtl/dmem_arb_wait_counter.sv | 29 ++
 rtl/dmem_arbiter.sv | 110 +++++++++++
 tb/tb_dmem_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the dmem arbiter: FSM states, port owner and wait-counter width.
// Imported by dmem_arbiter and arb_wait_counter.
package dmem_arb_pkg;

    localparam int WAIT_W = 8;

    typedef enum logic {
        ARB_NORMAL = 1'b0,
        ARB_FORCE  = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_PROC   = 1'b0,
        OWN_PERIPH = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/dmem_arb_wait_counter.sv
// Saturating count of cycles the peripheral has waited without a grant.
// at_max flags the count reaching MAX_WAIT, which arms the forced grant.
module arb_wait_counter
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic periph_req,
    input  logic periph_gnt,
    output logic at_max
);

    localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] r_wait_cnt;

    always_ff @(posedge clock) begin
        if (reset || !periph_req || periph_gnt) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt != MAX_CNT) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    assign at_max = (r_wait_cnt == MAX_CNT);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port dmem between the processor (fixed priority) and one peripheral.
// Optional starvation guard under macro DMEM_ARB_STARVE_EN: forces one peripheral slot and stalls the processor.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              proc_req,
    input  logic [ADDR_W-1:0] proc_address,
    input  logic [DATA_W-1:0] proc_data,
    input  logic              proc_wren,
    output logic [DATA_W-1:0] proc_q,
    output logic              proc_stall,
    input  logic              periph_req,
    input  logic              periph_wren,
    input  logic [ADDR_W-1:0] periph_address,
    input  logic [DATA_W-1:0] periph_wdata,
    output logic              periph_gnt,
    output logic              periph_rvalid,
    output logic [DATA_W-1:0] periph_rdata,
    output logic [ADDR_W-1:0] dmem_address,
    output logic [DATA_W-1:0] dmem_data,
    output logic              dmem_wren,
    input  logic [DATA_W-1:0] dmem_q
);

    arb_owner_t        w_owner;
    logic              w_force;
    logic              r_rvalid;
    logic [DATA_W-1:0] r_rdata;

`ifdef DMEM_ARB_STARVE_EN
    arb_state_t r_state;
    logic       w_at_max;

    arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_counter (
        .clock      (clock),
        .reset      (reset),
        .periph_req (periph_req),
        .periph_gnt (periph_gnt),
        .at_max     (w_at_max)
    );

    // FORCE lasts exactly one cycle; the grant it produces clears the counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ARB_NORMAL;
        end else begin
            case (r_state)
                ARB_NORMAL: r_state <= w_at_max ? ARB_FORCE : ARB_NORMAL;
                default:    r_state <= ARB_NORMAL;
            endcase
        end
    end

    assign w_force = (r_state == ARB_FORCE);
`else
    logic w_unused_max_wait;
    assign w_unused_max_wait = (MAX_WAIT > 0);
    assign w_force           = 1'b0;
`endif

    always_comb begin
        w_owner = OWN_PROC;
        if (w_force) begin
            w_owner = OWN_PERIPH;
        end else if (!proc_req && periph_req) begin
            w_owner = OWN_PERIPH;
        end
    end

    // Each requester's wren is qualified by its own request so an idle owner never writes.
    always_comb begin
        dmem_address = proc_address;
        dmem_data    = proc_data;
        dmem_wren    = proc_req && proc_wren && !reset;
        if (w_owner == OWN_PERIPH) begin
            dmem_address = periph_address;
            dmem_data    = periph_wdata;
            dmem_wren    = periph_req && periph_wren && !reset;
        end
    end

    assign periph_gnt = periph_req && (w_owner == OWN_PERIPH) && !reset;
    assign proc_stall = w_force;
    assign proc_q     = dmem_q;

    // dmem is clocked on the falling edge, so dmem_q holds the granted read by the next rising edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= periph_gnt && !periph_wren;
            if (periph_gnt && !periph_wren) begin
                r_rdata <= dmem_q;
            end
        end
    end

    assign periph_rvalid = r_rvalid && !reset;
    assign periph_rdata  = r_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a falling-edge dmem model; expectations track DMEM_ARB_STARVE_EN.
module tb_dmem_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic              proc_req;
    logic [ADDR_W-1:0] proc_address;
    logic [DATA_W-1:0] proc_data;
    logic              proc_wren;
    logic [DATA_W-1:0] proc_q;
    logic              proc_stall;
    logic              periph_req;
    logic              periph_wren;
    logic [ADDR_W-1:0] periph_address;
    logic [DATA_W-1:0] periph_wdata;
    logic              periph_gnt;
    logic              periph_rvalid;
    logic [DATA_W-1:0] periph_rdata;
    logic [ADDR_W-1:0] dmem_address;
    logic [DATA_W-1:0] dmem_data;
    logic              dmem_wren;
    logic [DATA_W-1:0] dmem_q = '0;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (dmem_wren) mem[dmem_address] <= dmem_data;
        dmem_q <= mem[dmem_address];
    end

    dmem_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_WAIT (4)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .proc_req       (proc_req),
        .proc_address   (proc_address),
        .proc_data      (proc_data),
        .proc_wren      (proc_wren),
        .proc_q         (proc_q),
        .proc_stall     (proc_stall),
        .periph_req     (periph_req),
        .periph_wren    (periph_wren),
        .periph_address (periph_address),
        .periph_wdata   (periph_wdata),
        .periph_gnt     (periph_gnt),
        .periph_rvalid  (periph_rvalid),
        .periph_rdata   (periph_rdata),
        .dmem_address   (dmem_address),
        .dmem_data      (dmem_data),
        .dmem_wren      (dmem_wren),
        .dmem_q         (dmem_q)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs;
        proc_req = 0; proc_wren = 0; proc_address = '0; proc_data = '0;
        periph_req = 0; periph_wren = 0; periph_address = '0; periph_wdata = '0;
    endtask

    task automatic test_reset;
        reset = 1; proc_req = 1; proc_wren = 1; proc_address = 12'h005; proc_data = 32'hA5A5A5A5;
        periph_req = 1; periph_wren = 1; periph_address = 12'h006; periph_wdata = 32'h5A5A5A5A;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++; if (periph_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt c%0d: got %b want 0", c, periph_gnt); end
            n_checks++; if (periph_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid c%0d: got %b want 0", c, periph_rvalid); end
            n_checks++; if (proc_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall c%0d: got %b want 0", c, proc_stall); end
            n_checks++; if (dmem_wren !== 1'b0) begin n_fail++; $display("FAIL reset_wren c%0d: got %b want 0", c, dmem_wren); end
        end
        reset = 0;
        idle_inputs();
        tick();
        n_checks++; if (periph_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", periph_rdata); end
    endtask

    task automatic test_idle_read;
        proc_req = 1; proc_wren = 1; proc_address = 12'h010; proc_data = 32'hDEADBEEF;
        #1;
        n_checks++; if (dmem_wren !== 1'b1) begin n_fail++; $display("FAIL store_wren: got %b want 1", dmem_wren); end
        tick();
        idle_inputs();
        periph_req = 1; periph_address = 12'h010;
        #1;
        n_checks++; if (periph_gnt !== 1'b1) begin n_fail++; $display("FAIL idle_gnt: got %b want 1", periph_gnt); end
        n_checks++; if (dmem_address !== 12'h010) begin n_fail++; $display("FAIL idle_addr: got %h want 010", dmem_address); end
        n_checks++; if (periph_rvalid !== 1'b0) begin n_fail++; $display("FAIL idle_rvalid_early: got %b want 0", periph_rvalid); end
        tick();
        periph_req = 0;
        #1;
        n_checks++; if (periph_rvalid !== 1'b1) begin n_fail++; $display("FAIL idle_rvalid: got %b want 1", periph_rvalid); end
        n_checks++; if (periph_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL idle_rdata: got %h want deadbeef", periph_rdata); end
        tick();
        n_checks++; if (periph_rvalid !== 1'b0) begin n_fail++; $display("FAIL idle_rvalid_late: got %b want 0", periph_rvalid); end
    endtask

    task automatic test_collision;
        proc_req = 1; proc_wren = 1; proc_address = 12'h020; proc_data = 32'h11111111;
        periph_req = 1; periph_wren = 1; periph_address = 12'h020; periph_wdata = 32'h22222222;
        #1;
        n_checks++; if (periph_gnt !== 1'b0) begin n_fail++; $display("FAIL coll_gnt_busy: got %b want 0", periph_gnt); end
        n_checks++; if (dmem_data !== 32'h11111111) begin n_fail++; $display("FAIL coll_proc_data: got %h want 11111111", dmem_data); end
        tick();
        proc_req = 0; proc_wren = 0;
        #1;
        n_checks++; if (periph_gnt !== 1'b1) begin n_fail++; $display("FAIL coll_gnt_idle: got %b want 1", periph_gnt); end
        n_checks++; if (dmem_data !== 32'h22222222) begin n_fail++; $display("FAIL coll_periph_data: got %h want 22222222", dmem_data); end
        n_checks++; if (dmem_wren !== 1'b1) begin n_fail++; $display("FAIL coll_periph_wren: got %b want 1", dmem_wren); end
        tick();
        periph_wren = 0;
        #1;
        n_checks++; if (periph_rvalid !== 1'b0) begin n_fail++; $display("FAIL coll_write_rvalid: got %b want 0", periph_rvalid); end
        tick();
        periph_req = 0;
        #1;
        n_checks++; if (periph_rdata !== 32'h22222222 || periph_rvalid !== 1'b1) begin n_fail++; $display("FAIL coll_final_read: got %h/%b want 22222222/1", periph_rdata, periph_rvalid); end
        tick();
    endtask

    task automatic test_back_to_back;
        periph_req = 1; periph_wren = 0; periph_address = 12'h010;
        #1;
        n_checks++; if (periph_gnt !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt0: got %b want 1", periph_gnt); end
        tick();
        periph_address = 12'h020;
        #1;
        n_checks++; if (periph_gnt !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt1: got %b want 1", periph_gnt); end
        n_checks++; if (periph_rvalid !== 1'b1 || periph_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL b2b_rd0: got %b/%h want 1/deadbeef", periph_rvalid, periph_rdata); end
        tick();
        periph_wren = 1; periph_address = 12'h030; periph_wdata = 32'h33333333;
        #1;
        n_checks++; if (periph_gnt !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt2: got %b want 1", periph_gnt); end
        n_checks++; if (periph_rvalid !== 1'b1 || periph_rdata !== 32'h22222222) begin n_fail++; $display("FAIL b2b_rd1: got %b/%h want 1/22222222", periph_rvalid, periph_rdata); end
        tick();
        idle_inputs();
        proc_wren = 1; proc_address = 12'h030; proc_data = 32'hBAD0BAD0;
        #1;
        n_checks++; if (periph_rvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_write_rvalid: got %b want 0", periph_rvalid); end
        n_checks++; if (dmem_wren !== 1'b0) begin n_fail++; $display("FAIL idle_wren_forced: got %b want 0", dmem_wren); end
        tick();
        idle_inputs();
        n_checks++; if (mem[12'h030] !== 32'h33333333) begin n_fail++; $display("FAIL b2b_mem030: got %h want 33333333", mem[12'h030]); end
    endtask

    task automatic test_starvation;
        logic e;
        proc_req = 1; proc_wren = 0; proc_address = 12'h001;
        periph_req = 1; periph_wren = 0; periph_address = 12'h010;
`ifdef DMEM_ARB_STARVE_EN
        for (int c = 0; c < 10; c++) begin
            if (c == 6) periph_req = 0;
            #1;
            e = (c == 5);
            n_checks++; if (periph_gnt !== e) begin n_fail++; $display("FAIL starve_gnt c%0d: got %b want %b", c, periph_gnt, e); end
            n_checks++; if (proc_stall !== e) begin n_fail++; $display("FAIL starve_stall c%0d: got %b want %b", c, proc_stall, e); end
            e = (c == 6);
            n_checks++; if (periph_rvalid !== e) begin n_fail++; $display("FAIL starve_rvalid c%0d: got %b want %b", c, periph_rvalid, e); end
            tick();
        end
        idle_inputs();
`else
        for (int c = 0; c < 100; c++) begin
            #1;
            n_checks++; if (periph_gnt !== 1'b0) begin n_fail++; $display("FAIL nostarve_gnt c%0d: got %b want 0", c, periph_gnt); end
            n_checks++; if (proc_stall !== 1'b0) begin n_fail++; $display("FAIL nostarve_stall c%0d: got %b want 0", c, proc_stall); end
            tick();
        end
        proc_req = 0;
        #1;
        n_checks++; if (periph_gnt !== 1'b1) begin n_fail++; $display("FAIL nostarve_drop_gnt: got %b want 1", periph_gnt); end
        tick();
        idle_inputs();
        #1;
        n_checks++; if (periph_rvalid !== 1'b1 || periph_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL nostarve_read: got %b/%h want 1/deadbeef", periph_rvalid, periph_rdata); end
        tick();
`endif
    endtask

    task automatic test_reset_mid_read;
        logic e;
        periph_req = 1; periph_wren = 0; periph_address = 12'h020;
        #1;
        n_checks++; if (periph_gnt !== 1'b1) begin n_fail++; $display("FAIL rmr_gnt: got %b want 1", periph_gnt); end
        tick();
        periph_req = 0; reset = 1;
        #1;
        n_checks++; if (periph_rvalid !== 1'b0) begin n_fail++; $display("FAIL rmr_rvalid_in_reset: got %b want 0", periph_rvalid); end
        tick();
        reset = 0;
        #1;
        n_checks++; if (periph_rvalid !== 1'b0) begin n_fail++; $display("FAIL rmr_rvalid_after: got %b want 0", periph_rvalid); end
        n_checks++; if (periph_rdata !== 32'h0) begin n_fail++; $display("FAIL rmr_rdata: got %h want 0", periph_rdata); end
        tick();
        proc_req = 1; periph_req = 1;
        for (int c = 0; c < 7; c++) begin
            if (c == 6) periph_req = 0;
            #1;
`ifdef DMEM_ARB_STARVE_EN
            e = (c == 5);
`else
            e = 1'b0;
`endif
            n_checks++; if (periph_gnt !== e) begin n_fail++; $display("FAIL rmr_regrant c%0d: got %b want %b", c, periph_gnt, e); end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        test_reset();
        test_idle_read();
        test_collision();
        test_back_to_back();
        test_starvation();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
